// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: EX/MEM forwarding, load-use bubble insertion, ID/EX pipeline register.
// Define ID_EX_PERF_EN to add the perf_stall_cnt / perf_fwd_cnt counters.

// Forward mux for one source operand; the first matching source wins.
module id_ex_fwd_sel (
  input  logic [4:0]  addr,
  input  logic [31:0] rfData,
  input  logic        exFwdEn,
  input  logic [4:0]  exDst,
  input  logic [31:0] exVal,
  input  logic        memFwdEn,
  input  logic [4:0]  memDst,
  input  logic [31:0] memVal,
  output logic [31:0] val,
  output logic        fwd
);
  always_comb begin
    val = rfData;
    fwd = 1'b0;
    // r0 reads are never bypassed; the register file already returns 0.
    if (addr != 5'd0) begin
      if (exFwdEn && exDst == addr) begin
        val = exVal;
        fwd = 1'b1;
      end else if (memFwdEn && memDst == addr) begin
        val = memVal;
        fwd = 1'b1;
      end
    end
  end
endmodule

module id_ex_operand_stage #(
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs_addr,
  input  logic [4:0]        id_rt_addr,
  input  logic [31:0]       id_rs_data,
  input  logic [31:0]       id_rt_data,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [4:0]        id_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       ex_alu_result,
  input  logic              mem_reg_write,
  input  logic [4:0]        mem_dst,
  input  logic [31:0]       mem_result,
  input  logic              ex_hold,
  input  logic              flush,
  output logic              stall_id,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [4:0]        ex_dst,
  output logic [31:0]       ex_rs_val,
  output logic [31:0]       ex_rt_val,
  output logic [31:0]       ex_imm,
`ifdef ID_EX_PERF_EN
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_fwd_cnt,
`endif
  output logic [CTRL_W-1:0] ex_ctrl
);
  logic [1:0][4:0]  srcAddr;
  logic [1:0][31:0] srcData;
  logic [1:0][31:0] srcVal;
  logic [1:0]       srcUse;
  logic [1:0]       srcFwd;
  logic [1:0]       srcLoadHit;
  logic             exFwdEn;
  logic             luse;
  logic             bubble;

  assign srcAddr = {id_rt_addr, id_rs_addr};
  assign srcData = {id_rt_data, id_rs_data};
  assign srcUse  = {id_uses_rt, id_uses_rs};
  // A load in EX has no data yet, so it is never an EX forward source.
  assign exFwdEn = ex_valid && ex_reg_write && !ex_mem_read;

  for (genvar s = 0; s < 2; s++) begin : gSrc
    id_ex_fwd_sel uFwd (
      .addr     (srcAddr[s]),
      .rfData   (srcData[s]),
      .exFwdEn  (exFwdEn),
      .exDst    (ex_dst),
      .exVal    (ex_alu_result),
      .memFwdEn (mem_reg_write),
      .memDst   (mem_dst),
      .memVal   (mem_result),
      .val      (srcVal[s]),
      .fwd      (srcFwd[s])
    );
    assign srcLoadHit[s] = srcUse[s] && (ex_dst == srcAddr[s]);
  end

  assign luse     = id_valid && ex_valid && ex_mem_read && (ex_dst != 5'd0) && (|srcLoadHit);
  assign stall_id = (luse && !flush) || ex_hold;
  assign bubble   = flush || !id_valid || luse;

  always_ff @(posedge clk) begin
    if (reset || (!ex_hold && bubble)) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_dst       <= '0;
      ex_rs_val    <= '0;
      ex_rt_val    <= '0;
      ex_imm       <= '0;
      ex_ctrl      <= '0;
    end else if (!ex_hold) begin
      ex_valid     <= 1'b1;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
      ex_dst       <= id_dst;
      ex_rs_val    <= srcVal[0];
      ex_rt_val    <= srcVal[1];
      ex_imm       <= id_imm;
      ex_ctrl      <= id_ctrl;
    end
  end

`ifdef ID_EX_PERF_EN
  // Stalls are counted only when the load-use hazard itself creates the bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else if (!ex_hold) begin
      if (luse && !flush)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (!bubble && (|srcFwd))
        perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
    end
  end
`else
  logic unusedFwd;
  assign unusedFwd = |srcFwd;
`endif
endmodule
